conv3x3_stream: RTL

//  Streaming 3x3 convolution engine, mode-selectable (Gaussian/edge/sharpen/bypass).

---
 rtl/conv3x3_stream.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution over a raster-order frame.
// It keeps two lines of history and builds a 3x3 window for each accepted
// beat. Every interior window produces one output pixel. There are two
// pipeline stages: weighted sums, then normalise/clamp.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   mode       filter select (0 Gaussian, 1 edge, 2 sharpen, 3 bypass),
//              latched on the accepted in_sof beat
//   in_valid   input beat qualifier (no backpressure)
//   in_sof     first pixel of a frame, qualified by in_valid
//   in_pixel   unsigned input pixel
//   out_valid  output beat qualifier
//   out_pixel  filtered pixel, held while out_valid is low
//   out_eof    marks the last interior output of a frame
//   frame_err  one-cycle pulse when in_sof arrives before a frame completes
module conv3x3_stream #(
    parameter int DATA_W = 13,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_eof,
    output logic              frame_err
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int ACC_W = DATA_W + 6;

    localparam logic [CW-1:0]           COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]           ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [1:0]         mode_q, mode_d;
    logic               frame_err_q, frame_err_d;

    // Line buffers are addressed by column.
    // lb1 holds row r-1 and lb2 holds row r-2.
    logic [DATA_W-1:0]  lb1_q [IMG_W];
    logic [DATA_W-1:0]  lb1_d [IMG_W];
    logic [DATA_W-1:0]  lb2_q [IMG_W];
    logic [DATA_W-1:0]  lb2_d [IMG_W];

    // Window columns: wa = col-2, wb = col-1, nw = current column.
    // Index 0 = row r-2, index 1 = row r-1, index 2 = row r.
    logic [DATA_W-1:0]  wa_q [3];
    logic [DATA_W-1:0]  wa_d [3];
    logic [DATA_W-1:0]  wb_q [3];
    logic [DATA_W-1:0]  wb_d [3];
    logic [DATA_W-1:0]  nw   [3];

    logic               s1_valid_q, s1_valid_d;
    logic               s1_eof_q, s1_eof_d;
    logic [1:0]         s1_mode_q, s1_mode_d;
    logic signed [ACC_W-1:0] s1_val_q, s1_val_d;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_pixel_q, out_pixel_d;
    logic               out_eof_q, out_eof_d;

    logic               accept;
    logic               win_done;
    logic               last_beat;
    logic [CW-1:0]      bcol;
    logic [RW-1:0]      brow;

    logic signed [ACC_W-1:0] t0, t1, t2, m0, cc, m2, b0, b1, b2;
    logic signed [ACC_W-1:0] n4, n8, gauss, edge_s, sharp_s;
    logic signed [ACC_W-1:0] abs_v;
    logic [DATA_W-1:0]       res;

    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] x);
        return $signed({{(ACC_W-DATA_W){1'b0}}, x});
    endfunction

    // Beat position and frame state.
    always_comb begin
        accept      = in_valid && (in_sof || state_q == ST_FRAME);
        bcol        = in_sof ? '0 : col_q;
        brow        = in_sof ? '0 : row_q;
        win_done    = accept && (brow >= RW'(2)) && (bcol >= CW'(2));
        last_beat   = (bcol == COL_LAST) && (brow == ROW_LAST);

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        frame_err_d = in_valid && in_sof && (state_q == ST_FRAME);

        if (accept) begin
            if (in_sof) begin
                mode_d = mode;
            end
            if (bcol == COL_LAST) begin
                col_d = '0;
                if (brow == ROW_LAST) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d   = brow + 1'b1;
                    state_d = ST_FRAME;
                end
            end else begin
                col_d   = bcol + 1'b1;
                row_d   = brow;
                state_d = ST_FRAME;
            end
        end
    end

    // Line buffers and the shift window advance only on accepted beats.
    always_comb begin
        lb1_d = lb1_q;
        lb2_d = lb2_q;
        wa_d  = wa_q;
        wb_d  = wb_q;
        nw[0] = lb2_q[bcol];
        nw[1] = lb1_q[bcol];
        nw[2] = in_pixel;
        if (accept) begin
            lb2_d[bcol] = lb1_q[bcol];
            lb1_d[bcol] = in_pixel;
            wa_d        = wb_q;
            wb_d        = nw;
        end
    end

    // Stage 1: the weighted sum for the selected mode.
    // The window is formed from the registered columns and the new column.
    always_comb begin
        t0 = ext(wa_q[0]);  t1 = ext(wb_q[0]);  t2 = ext(nw[0]);
        m0 = ext(wa_q[1]);  cc = ext(wb_q[1]);  m2 = ext(nw[1]);
        b0 = ext(wa_q[2]);  b1 = ext(wb_q[2]);  b2 = ext(nw[2]);

        n4      = t1 + m0 + m2 + b1;
        n8      = n4 + t0 + t2 + b0 + b2;
        gauss   = t0 + t2 + b0 + b2 + ((t1 + m0 + m2 + b1) <<< 1) + (cc <<< 2);
        edge_s  = (cc <<< 3) - n8;
        sharp_s = (cc <<< 2) + cc - n4;

        s1_valid_d = win_done;
        s1_eof_d   = win_done && last_beat;
        s1_mode_d  = mode_q;
        s1_val_d   = s1_val_q;
        if (win_done) begin
            case (mode_q)
                2'd0:    s1_val_d = gauss;
                2'd1:    s1_val_d = edge_s;
                2'd2:    s1_val_d = sharp_s;
                default: s1_val_d = cc;
            endcase
        end
    end

    // Stage 2: normalise and clamp to the pixel range.
    always_comb begin
        abs_v = (s1_val_q < 0) ? -s1_val_q : s1_val_q;
        case (s1_mode_q)
            2'd0: res = s1_val_q[DATA_W+3:4];
            2'd1: res = (abs_v > PIX_MAX) ? '1 : abs_v[DATA_W-1:0];
            2'd2: begin
                if (s1_val_q < 0)             res = '0;
                else if (s1_val_q > PIX_MAX)  res = '1;
                else                          res = s1_val_q[DATA_W-1:0];
            end
            default: res = s1_val_q[DATA_W-1:0];
        endcase

        out_valid_d = s1_valid_q;
        out_pixel_d = s1_valid_q ? res : out_pixel_q;
        out_eof_d   = s1_valid_q && s1_eof_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            frame_err_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_mode_q   <= '0;
            s1_val_q    <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            frame_err_q <= frame_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_eof_q    <= s1_eof_d;
            s1_mode_q   <= s1_mode_d;
            s1_val_q    <= s1_val_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Pixel storage is not reset.
    // No window can complete until a new frame has refilled it.
    always_ff @(posedge clk) begin
        lb1_q <= lb1_d;
        lb2_q <= lb2_d;
        wa_q  <= wa_d;
        wb_q  <= wb_d;
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_eof   = out_eof_q;
    assign frame_err = frame_err_q;

endmodule
